reg_file_scoreboard: RTL

Parametrised register file for the RISC-V datapath, replacing the fixed 32x32 register file. It has two combinational read ports and one clocked write port. It adds an optional hardwired-zero register 0, optional write-to-read forwarding, a per-register pending-write scoreboard for pipeline hazard detection, and a sequential clear-all sweep. It sits between decode (reads, issue) and writeback (writes).

---
 rtl/reg_file_scoreboard_if.sv | 47 ++++
 rtl/reg_file_scoreboard.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard_if.sv
// ----------------------------------------------------------------------------
// reg_file_scoreboard_if
//
// Bundles the read, write, issue and maintenance signals of the register
// file. Clock and reset are kept out of the interface.
//
//   master : decode/writeback side. Drives addresses, write data and
//            control. Receives read data, busy flags and sweep status.
//   slave  : the register file itself.
//
//   rs1_addr/rs2_addr  read indices          rs1_data/rs2_data  read data
//   rs1_busy/rs2_busy  pending-write flags   hazard             rs1|rs2 busy
//   we/wr_addr/wr_data write port            issue_valid/issue_rd  mark busy
//   flush              clear all busy bits   clr_start/clr_busy    sweep
// ----------------------------------------------------------------------------
interface reg_file_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              hazard;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              flush;
    logic              clr_start;
    logic              clr_busy;

    modport master (
        output rs1_addr, rs2_addr, we, wr_addr, wr_data,
               issue_valid, issue_rd, flush, clr_start,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, hazard, clr_busy
    );

    modport slave (
        input  rs1_addr, rs2_addr, we, wr_addr, wr_data,
               issue_valid, issue_rd, flush, clr_start,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, hazard, clr_busy
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// ----------------------------------------------------------------------------
// reg_file_scoreboard
//
// Parametrised register file with two combinational read ports and one
// clocked write port. It also provides:
//   - an optional hardwired-zero register 0,
//   - optional forwarding of same-cycle write data to the read ports,
//   - a per-register pending-write scoreboard used for hazard detection,
//   - a sequential clear-all sweep that zeroes one register per cycle.
//
// Ports:
//   clock  rising-edge clock for all state
//   reset  asynchronous, active-low
//   bus    reg_file_scoreboard_if.slave (read/write/issue/flush/sweep)
// ----------------------------------------------------------------------------
module reg_file_scoreboard #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter bit ZERO_REG      = 1'b1,
    parameter bit BYPASS        = 1'b1,
    parameter bit RESET_PATTERN = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    reg_file_scoreboard_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;

    logic wr_ok;
    logic rs1_hit;
    logic rs2_hit;

    // Value loaded into register idx by reset.
    function automatic logic [DATA_W-1:0] reset_value(input int idx);
        if (ZERO_REG && idx == 0) begin
            return '0;
        end
        if (RESET_PATTERN) begin
            return DATA_W'(idx);
        end
        return '0;
    endfunction

    // True when addr names the hardwired-zero register.
    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return ZERO_REG && (addr == '0);
    endfunction

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    // Writes are only accepted in IDLE, so the sweep automatically disables
    // both the write port and forwarding.
    assign wr_ok = bus.we && (state_q == ST_IDLE) && !is_zero(bus.wr_addr);

    always_comb begin
        rs1_hit = BYPASS && wr_ok && (bus.wr_addr == bus.rs1_addr);
        rs2_hit = BYPASS && wr_ok && (bus.wr_addr == bus.rs2_addr);

        bus.rs1_data = mem_q[bus.rs1_addr];
        if (rs1_hit) begin
            bus.rs1_data = bus.wr_data;
        end
        if (is_zero(bus.rs1_addr)) begin
            bus.rs1_data = '0;
        end

        bus.rs2_data = mem_q[bus.rs2_addr];
        if (rs2_hit) begin
            bus.rs2_data = bus.wr_data;
        end
        if (is_zero(bus.rs2_addr)) begin
            bus.rs2_data = '0;
        end

        // A writeback landing this cycle already resolves the hazard when
        // its data is being forwarded.
        bus.rs1_busy = busy_q[bus.rs1_addr] && !rs1_hit && !is_zero(bus.rs1_addr);
        bus.rs2_busy = busy_q[bus.rs2_addr] && !rs2_hit && !is_zero(bus.rs2_addr);
        bus.hazard   = bus.rs1_busy || bus.rs2_busy;
    end

    assign bus.clr_busy = (state_q == ST_SWEEP);

    // ------------------------------------------------------------------
    // Next-state: array, scoreboard, sweep FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_ok) begin
                    mem_d[bus.wr_addr]  = bus.wr_data;
                    busy_d[bus.wr_addr] = 1'b0;
                end
                // Issue is applied after the writeback clear so a same-cycle
                // issue/write on one index leaves the bit set.
                if (bus.issue_valid && !is_zero(bus.issue_rd)) begin
                    busy_d[bus.issue_rd] = 1'b1;
                end
                if (bus.flush || bus.clr_start) begin
                    busy_d = '0;
                end
                if (bus.clr_start) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end

            ST_SWEEP: begin
                mem_d[cnt_q] = '0;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= reset_value(i);
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            mem_q   <= mem_d;
        end
    end

endmodule
